// File: rtl/ks_pkg.sv
// Shared constants and types for the Karplus-Strong excitation path.
package ks_pkg;

  localparam int          LFSR_W     = 32;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED  = 32'hACE1_0001;
  localparam logic [8:0]  UNITY_GAIN = 9'd256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2
  } state_t;

  function automatic logic [8:0] clamp_gain(input logic [8:0] gain);
    return (gain > UNITY_GAIN) ? UNITY_GAIN : gain;
  endfunction

endpackage

// File: rtl/ks_lfsr.sv
// 32-bit right-shifting Galois LFSR noise source, one step per advance.
module ks_lfsr
  import ks_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] state_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= LFSR_SEED;
    end else if (advance) begin
      state_reg <= {1'b0, state_reg[LFSR_W-1:1]} ^ (state_reg[0] ? LFSR_POLY : '0);
    end
  end

  assign value = state_reg;

endmodule

// File: rtl/ks_exciter.sv
// Pluck excitation: amplitude-scaled noise burst of programmable length,
// stepped by the sample strobe, silent otherwise.
module ks_exciter
  import ks_pkg::*;
#(
  parameter int datawidth = 16,
  parameter int lenbits   = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ena,
  input  logic                 trigger,
  input  logic [8:0]           amplitude,
  input  logic [lenbits-1:0]   length,
  output logic [datawidth-1:0] q,
  output logic                 busy
);

  logic [LFSR_W-1:0]           lfsr_value;
  state_t                      state_reg;
  logic [datawidth-1:0]        q_reg;
  logic                        busy_reg;
  logic [lenbits-1:0]          count_reg;
  logic [lenbits-1:0]          len_reg;
  logic [8:0]                  amp_reg;
  logic signed [datawidth+9:0] product;
  logic [datawidth-1:0]        scaled;
  logic                        accept;

  ks_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (ena),
    .value   (lfsr_value)
  );

  // Gain is at most 256, so bits above datawidth+7 only carry sign.
  assign product = $signed(lfsr_value[datawidth-1:0]) * $signed({1'b0, amp_reg});
  assign scaled  = product[datawidth+7:8];
  assign accept  = trigger && (length != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      busy_reg  <= 1'b0;
      count_reg <= '0;
      len_reg   <= '0;
      amp_reg   <= '0;
    end else begin
      if (ena) begin
        case (state_reg)
          IDLE: begin
            q_reg <= '0;
          end
          ARMED: begin
            q_reg     <= scaled;
            count_reg <= len_reg - lenbits'(1);
            if (len_reg == lenbits'(1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= BURST;
            end
          end
          BURST: begin
            q_reg     <= scaled;
            count_reg <= count_reg - lenbits'(1);
            if (count_reg == lenbits'(1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
      // A pluck overrides whatever the strobe did to the state; the strobe's
      // output sample still follows the pre-trigger state.
      if (accept) begin
        amp_reg   <= clamp_gain(amplitude);
        len_reg   <= length;
        state_reg <= ARMED;
        busy_reg  <= 1'b1;
      end
    end
  end

  assign q    = q_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_ks_exciter.sv
// Directed self-checking bench for ks_exciter with a software LFSR model.
module tb_ks_exciter;

  localparam int DW = 16;
  localparam int LB = 12;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ena;
  logic          trigger;
  logic [8:0]    amplitude;
  logic [LB-1:0] length;
  logic [DW-1:0] q;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_lfsr;

  ks_exciter #(.datawidth(DW), .lenbits(LB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .trigger   (trigger),
    .amplitude (amplitude),
    .length    (length),
    .q         (q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic pulse_ena(output logic [31:0] pre);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    pre = m_lfsr;
    m_lfsr = model_step(m_lfsr);
  endtask

  task automatic pluck(input logic [8:0] amp, input logic [LB-1:0] len);
    trigger = 1'b1;
    amplitude = amp;
    length = len;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ena = 1'b0; trigger = 1'b0; amplitude = '0; length = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q: got %h want 0000", q); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
  endtask

  task automatic test_idle_ena;
    logic [31:0] pre;
    for (int i = 0; i < 10; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_ena%0d: q=%h busy=%b want 0000/0", i, q, busy);
      end
    end
  endtask

  task automatic test_unity;
    logic [31:0] pre;
    pluck(9'd256, 12'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL unity_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL unity_s%0d: got %h want %h", i, q, pre[15:0]); end
      checks++;
      if (busy !== (i < 3)) begin errors++; $display("FAIL unity_busy%0d: got %b want %b", i, busy, i < 3); end
    end
    pulse_ena(pre);
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL unity_tail: q=%h busy=%b want 0000/0", q, busy); end
  endtask

  task automatic test_amplitude;
    logic [31:0] pre;
    logic signed [DW-1:0] n;
    logic [DW-1:0] expv;
    pluck(9'd128, 12'd8);
    for (int i = 0; i < 8; i++) begin
      pulse_ena(pre);
      n = pre[15:0];
      expv = n >>> 1;
      checks++;
      if (q !== expv) begin errors++; $display("FAIL half_s%0d: got %h want %h", i, q, expv); end
    end
    pluck(9'd400, 12'd8);
    for (int i = 0; i < 8; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL clamp_s%0d: got %h want %h", i, q, pre[15:0]); end
    end
    pulse_ena(pre);
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL clamp_tail: q=%h busy=%b want 0000/0", q, busy); end
  endtask

  task automatic test_retrigger;
    logic [31:0] pre;
    pluck(9'd256, 12'd100);
    for (int i = 0; i < 3; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL retrig_a%0d: got %h want %h", i, q, pre[15:0]); end
    end
    pluck(9'd256, 12'd5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL retrig_busy: got %b want 1", busy); end
    for (int i = 0; i < 5; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL retrig_b%0d: got %h want %h", i, q, pre[15:0]); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL retrig_busy_fall: got %b want 0", busy); end
    pulse_ena(pre);
    checks++;
    if (q !== '0) begin errors++; $display("FAIL retrig_tail: got %h want 0000", q); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] pre;
    trigger = 1'b1; ena = 1'b1; amplitude = 9'd256; length = 12'd2;
    @(negedge clk);
    trigger = 1'b0; ena = 1'b0;
    m_lfsr = model_step(m_lfsr);
    checks++;
    if (q !== '0 || busy !== 1'b1) begin errors++; $display("FAIL same_cycle: q=%h busy=%b want 0000/1", q, busy); end
    for (int i = 0; i < 2; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL same_s%0d: got %h want %h", i, q, pre[15:0]); end
    end
    pulse_ena(pre);
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL same_tail: q=%h busy=%b want 0000/0", q, busy); end
    pluck(9'd256, 12'd0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
    pulse_ena(pre);
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL len0_q: q=%h busy=%b want 0000/0", q, busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] pre;
    pluck(9'd256, 12'd6);
    pulse_ena(pre);
    checks++;
    if (q !== pre[15:0]) begin errors++; $display("FAIL rst_s0: got %h want %h", q, pre[15:0]); end
    reset_n = 1'b0; ena = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; ena = 1'b0;
    m_lfsr = SEED;
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: q=%h busy=%b want 0000/0", q, busy); end
    pluck(9'd256, 12'd3);
    pulse_ena(pre);
    checks++;
    if (q !== 16'h0001) begin errors++; $display("FAIL rst_seed: got %h want 0001", q); end
    for (int i = 0; i < 2; i++) begin
      pulse_ena(pre);
      checks++;
      if (q !== pre[15:0]) begin errors++; $display("FAIL rst_s%0d: got %h want %h", i + 1, q, pre[15:0]); end
    end
    pulse_ena(pre);
    checks++;
    if (q !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_tail: q=%h busy=%b want 0000/0", q, busy); end
  endtask

  initial begin
    test_reset();
    test_idle_ena();
    test_unity();
    test_amplitude();
    test_retrigger();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
